// File: rtl/hex_scroll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hex_pkg
//  Purpose  : Shared constants for the scrolling seven-segment controller.
//             Holds the active-low digit patterns {g,f,e,d,c,b,a}, the
//             all-off pattern and the controller state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package hex_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/hex_digit_dec.sv
`default_nettype none
// ============================================================================
//  Module   : hex_digit_dec
//  Purpose  : Combinational hex nibble to active-low seven-segment decoder.
//  Ports    : i_nib [3:0]  nibble to display
//             o_seg [6:0]  active-low segments {g,f,e,d,c,b,a}
//  Revision : 1.0 - initial release
// ============================================================================
module hex_digit_dec
  import hex_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hex_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hex_scroll_ctrl
//  Purpose  : Buffers up to DEPTH bytes and scrolls through them on the
//             seven-segment bank: HEX2 = buffer index, HEX1:HEX0 = byte,
//             each shown for DWELL cycles with an optional BLANK_CYC gap.
//  Ports    : clk, clrn (sync active-low reset)
//             in_valid/in_data/in_ready  byte write port (IDLE only)
//             start (pulse), pause (level), clear (pulse)
//             busy, count, HEX2/HEX1/HEX0 (registered, active-low)
//  Revision : 1.0 - initial release
// ============================================================================
module hex_scroll_ctrl
  import hex_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int DWELL     = 50_000_000,
  parameter int BLANK_CYC = 5_000_000
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     clear,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic [6:0]               HEX2,
  output logic [6:0]               HEX1,
  output logic [6:0]               HEX0
);

  localparam int IW   = $clog2(DEPTH);
  localparam int CW   = IW + 1;
  localparam int MAXC = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int TW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] c_depth      = CW'(DEPTH);
  localparam logic [TW-1:0] c_dwell_load = TW'(DWELL - 1);
  localparam logic [TW-1:0] c_gap_load   = (BLANK_CYC > 0) ? TW'(BLANK_CYC - 1) : '0;
  localparam bit            c_has_gap    = (BLANK_CYC > 0);

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_timer;
  logic [7:0]      r_buf [DEPTH];
  logic [6:0]      r_hex2, r_hex1, r_hex0;

  logic            w_wr;
  logic [CW-1:0]   w_count_nxt;
  logic            w_idx_last;
  logic [IW-1:0]   w_idx_nxt;
  logic [7:0]      w_byte;
  logic [3:0]      w_idx_nib;
  logic [6:0]      w_seg2, w_seg1, w_seg0;
  logic            w_freeze;

  assign in_ready    = (r_state == IDLE) && (r_count < c_depth);
  assign busy        = (r_state != IDLE);
  assign count       = r_count;
  assign HEX2        = r_hex2;
  assign HEX1        = r_hex1;
  assign HEX0        = r_hex0;

  // A write is only possible in IDLE since in_ready is low elsewhere;
  // clear drops any coincident write.
  assign w_wr        = in_valid && in_ready && !clear;
  // Occupancy including a same-cycle write, so write+start works at count 0.
  assign w_count_nxt = r_count + {{(CW-1){1'b0}}, w_wr};
  assign w_idx_last  = ({1'b0, r_idx} == (r_count - CW'(1)));
  assign w_idx_nxt   = w_idx_last ? '0 : r_idx + IW'(1);

  assign w_byte      = r_buf[r_idx];
  assign w_idx_nib   = 4'(r_idx);
  // Outputs hold while paused in an active state; clear overrides pause.
  assign w_freeze    = pause && busy && !clear;

  hex_digit_dec u_dec2 (.i_nib(w_idx_nib),    .o_seg(w_seg2));
  hex_digit_dec u_dec1 (.i_nib(w_byte[7:4]),  .o_seg(w_seg1));
  hex_digit_dec u_dec0 (.i_nib(w_byte[3:0]),  .o_seg(w_seg0));

  // Control state, index, occupancy and dwell/gap timer
  always_ff @(posedge clk) begin
    if (!clrn || clear) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_count <= '0;
      r_timer <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= w_count_nxt;
          if (start && (w_count_nxt != '0)) begin
            r_state <= SHOW;
            r_idx   <= '0;
            r_timer <= c_dwell_load;
          end
        end
        SHOW: begin
          if (!pause) begin
            if (r_timer == '0) begin
              if (c_has_gap) begin
                r_state <= GAP;
                r_timer <= c_gap_load;
              end else begin
                r_idx   <= w_idx_nxt;
                r_timer <= c_dwell_load;
              end
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
        end
        GAP: begin
          if (!pause) begin
            if (r_timer == '0) begin
              r_state <= SHOW;
              r_idx   <= w_idx_nxt;
              r_timer <= c_dwell_load;
            end else begin
              r_timer <= r_timer - TW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Byte buffer; contents are not reset because clear makes them don't-care
  always_ff @(posedge clk) begin
    if (clrn && w_wr) begin
      r_buf[r_count[IW-1:0]] <= in_data;
    end
  end

  // Segment registers follow the current state, so they lag it by one cycle
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_hex2 <= SEG_BLANK;
      r_hex1 <= SEG_BLANK;
      r_hex0 <= SEG_BLANK;
    end else if (!w_freeze) begin
      if (r_state == SHOW) begin
        r_hex2 <= w_seg2;
        r_hex1 <= w_seg1;
        r_hex0 <= w_seg0;
      end else begin
        r_hex2 <= SEG_BLANK;
        r_hex1 <= SEG_BLANK;
        r_hex0 <= SEG_BLANK;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_scroll_ctrl
//  Purpose  : Directed self-checking bench for hex_scroll_ctrl. Instance "a"
//             uses DEPTH=4, DWELL=4, BLANK_CYC=2; instance "b" uses the
//             same with BLANK_CYC=0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hex_scroll_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_clrn, a_in_valid, a_in_ready, a_start, a_pause, a_clear, a_busy;
  logic [7:0] a_in_data;
  logic [2:0] a_count;
  logic [6:0] a_hex2, a_hex1, a_hex0;

  logic       b_clrn, b_in_valid, b_in_ready, b_start, b_pause, b_clear, b_busy;
  logic [7:0] b_in_data;
  logic [2:0] b_count;
  logic [6:0] b_hex2, b_hex1, b_hex0;

  hex_scroll_ctrl #(.DEPTH(4), .DWELL(4), .BLANK_CYC(2)) dut_a (
    .clk(clk), .clrn(a_clrn), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .start(a_start), .pause(a_pause), .clear(a_clear),
    .busy(a_busy), .count(a_count), .HEX2(a_hex2), .HEX1(a_hex1), .HEX0(a_hex0)
  );

  hex_scroll_ctrl #(.DEPTH(4), .DWELL(4), .BLANK_CYC(0)) dut_b (
    .clk(clk), .clrn(b_clrn), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .start(b_start), .pause(b_pause), .clear(b_clear),
    .busy(b_busy), .count(b_count), .HEX2(b_hex2), .HEX1(b_hex1), .HEX0(b_hex0)
  );

  // Hand-derived segment triples {HEX2,HEX1,HEX0}
  localparam logic [20:0] BL    = {7'h7F, 7'h7F, 7'h7F};
  localparam logic [20:0] E_3A  = {7'h40, 7'h30, 7'h08}; // 0 / 3 / A
  localparam logic [20:0] E_F0  = {7'h79, 7'h0E, 7'h40}; // 1 / F / 0
  localparam logic [20:0] E_11  = {7'h40, 7'h79, 7'h79}; // 0 / 1 / 1
  localparam logic [20:0] E_22  = {7'h79, 7'h24, 7'h24}; // 1 / 2 / 2
  localparam logic [20:0] E_33  = {7'h24, 7'h30, 7'h30}; // 2 / 3 / 3
  localparam logic [20:0] E_44  = {7'h30, 7'h19, 7'h19}; // 3 / 4 / 4
  localparam logic [20:0] E_5C  = {7'h40, 7'h12, 7'h46}; // 0 / 5 / C

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] hexa();
    return {a_hex2, a_hex1, a_hex0};
  endfunction

  function automatic logic [20:0] hexb();
    return {b_hex2, b_hex1, b_hex0};
  endfunction

  logic [20:0] exp_hex;
  logic [20:0] ent [4];

  initial begin
    ent[0] = E_11; ent[1] = E_22; ent[2] = E_33; ent[3] = E_44;
    a_clrn = 1'b0; a_in_valid = 1'b0; a_in_data = 8'h00;
    a_start = 1'b0; a_pause = 1'b0; a_clear = 1'b0;
    b_clrn = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00;
    b_start = 1'b0; b_pause = 1'b0; b_clear = 1'b0;
    tick; tick;
    a_clrn = 1'b1; b_clrn = 1'b1;

    // Reset state
    chk("rst_busy",  32'(a_busy), 32'd0);
    chk("rst_count", 32'(a_count), 32'd0);
    chk("rst_ready", 32'(a_in_ready), 32'd1);
    chk("rst_hex",   32'(hexa()), 32'(BL));

    // Two writes then start
    a_in_valid = 1'b1; a_in_data = 8'h3A; tick;
    a_in_data = 8'hF0; tick;
    a_in_valid = 1'b0;
    chk("wr2_count", 32'(a_count), 32'd2);
    a_start = 1'b1; tick; a_start = 1'b0;
    chk("start_busy", 32'(a_busy), 32'd1);
    chk("start_hex_lag", 32'(hexa()), 32'(BL));
    chk("show_ready", 32'(a_in_ready), 32'd0);

    // 4 show / 2 blank per entry, alternating entries
    for (int k = 0; k < 13; k++) begin
      tick;
      if ((k % 6) < 4) exp_hex = (((k / 6) % 2) == 0) ? E_3A : E_F0;
      else             exp_hex = BL;
      chk($sformatf("scroll_k%0d", k), 32'(hexa()), 32'(exp_hex));
    end
    chk("scroll_busy", 32'(a_busy), 32'd1);

    // Pause mid-SHOW: one dwell cycle already elapsed
    a_pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick;
      chk($sformatf("pause_k%0d", k), 32'(hexa()), 32'(E_3A));
    end
    a_pause = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("resume_k%0d", k), 32'(hexa()), 32'(E_3A));
    end
    tick;
    chk("resume_gap", 32'(hexa()), 32'(BL));
    chk("gap_busy", 32'(a_busy), 32'd1);

    // clear with write and start during GAP
    a_clear = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h99; a_start = 1'b1;
    tick;
    a_clear = 1'b0; a_in_valid = 1'b0; a_start = 1'b0;
    chk("clr_busy",  32'(a_busy), 32'd0);
    chk("clr_count", 32'(a_count), 32'd0);
    chk("clr_ready", 32'(a_in_ready), 32'd1);
    chk("clr_hex",   32'(hexa()), 32'(BL));

    // start with empty buffer is ignored
    a_start = 1'b1; tick; a_start = 1'b0;
    chk("empty_busy", 32'(a_busy), 32'd0);
    tick;
    chk("empty_busy2", 32'(a_busy), 32'd0);
    chk("empty_hex", 32'(hexa()), 32'(BL));

    // Five back-to-back writes into a 4-deep buffer
    a_in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      a_in_data = 8'(i * 8'h11);
      tick;
      chk($sformatf("fill_count%0d", i), 32'(a_count), (i < 4) ? 32'(i) : 32'd4);
      chk($sformatf("fill_ready%0d", i), 32'(a_in_ready), (i < 4) ? 32'd1 : 32'd0);
    end
    a_in_valid = 1'b0;
    a_start = 1'b1; tick; a_start = 1'b0;
    tick;
    chk("fill_e0", 32'(hexa()), 32'(ent[0]));
    for (int k = 1; k <= 4; k++) begin
      repeat (5) tick;
      tick;
      chk($sformatf("fill_e%0d", k), 32'(hexa()), 32'(ent[k % 4]));
    end

    // Reset mid-operation
    a_clrn = 1'b0; tick; a_clrn = 1'b1;
    chk("rst2_busy",  32'(a_busy), 32'd0);
    chk("rst2_count", 32'(a_count), 32'd0);
    chk("rst2_ready", 32'(a_in_ready), 32'd1);
    chk("rst2_hex",   32'(hexa()), 32'(BL));

    // No-gap build: single entry shown continuously
    b_in_valid = 1'b1; b_in_data = 8'h5C; tick;
    b_in_valid = 1'b0; b_start = 1'b1; tick; b_start = 1'b0;
    for (int k = 0; k < 13; k++) begin
      tick;
      chk($sformatf("nogap_k%0d", k), 32'(hexb()), 32'(E_5C));
    end
    chk("nogap_busy", 32'(b_busy), 32'd1);
    b_clrn = 1'b0; tick; b_clrn = 1'b1;
    chk("b_rst_busy",  32'(b_busy), 32'd0);
    chk("b_rst_count", 32'(b_count), 32'd0);
    chk("b_rst_ready", 32'(b_in_ready), 32'd1);
    chk("b_rst_hex",   32'(hexb()), 32'(BL));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
